csel_sub64_seq: RTL and testbench

//  Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, one 8-bit slice per clock.

---
 rtl/csel_sub64_seq.sv | 153 +++++++++++++++
 tb/tb_csel_sub64_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/csel_sub64_seq.sv
// Sequential WIDTH-bit subtractor (a - b - bin). Each clock processes one 8-bit
// carry-select slice, so a result takes WIDTH/8 cycles.
module csel_sub64_seq #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NS = WIDTH / 8;
    localparam int unsigned CW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_last;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_nb;
    logic             r_carry;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [7:0]       w_a_sl;
    logic [7:0]       w_b_sl;
    logic [4:0]       w_lo;
    logic [4:0]       w_hi0;
    logic [4:0]       w_hi1;
    logic [4:0]       w_hi;
    logic [7:0]       w_slice;
    logic             w_cout;
    logic [WIDTH-1:0] w_diff_nxt;

    assign w_last = (r_cnt == CW'(NS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_RUN;
                    w_accept    = 1'b1;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake flags registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
        end
    end

    // One carry-select slice: high nibble precomputed for both low-nibble carries
    always_comb begin
        w_a_sl     = r_a[{r_cnt, 3'b000} +: 8];
        w_b_sl     = r_nb[{r_cnt, 3'b000} +: 8];
        w_lo       = 5'(w_a_sl[3:0]) + 5'(w_b_sl[3:0]) + 5'(r_carry);
        w_hi0      = 5'(w_a_sl[7:4]) + 5'(w_b_sl[7:4]);
        w_hi1      = w_hi0 + 5'd1;
        w_hi       = w_lo[4] ? w_hi1 : w_hi0;
        w_slice    = {w_hi[3:0], w_lo[3:0]};
        w_cout     = w_hi[4];
        w_diff_nxt = r_diff;
        w_diff_nxt[{r_cnt, 3'b000} +: 8] = w_slice;
    end

    // Operand capture, slice accumulation and final flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_nb    <= '0;
            r_carry <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_nb    <= ~b;
            r_carry <= ~bin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_diff  <= w_diff_nxt;
            r_carry <= w_cout;
            r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
            if (w_last) begin
                // a and b differ in sign exactly when a and ~b share the MSB
                r_bout <= ~w_cout;
                r_ovf  <= (r_a[WIDTH-1] == r_nb[WIDTH-1]) && (w_slice[7] != r_a[WIDTH-1]);
                r_zero <= (w_diff_nxt == '0);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_csel_sub64_seq.sv
// Bench for csel_sub64_seq: directed and random operands compared against a
// plain-arithmetic model, plus latency, handshake and mid-run reset checks.
module tb_csel_sub64_seq;

    localparam int WIDTH = 64;
    localparam int NS    = WIDTH / 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    int n_checks = 0;
    int n_errors = 0;

    csel_sub64_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Accept one operation, wait for the result, check it, optionally stall, then hand off
    task automatic run_op(input string name, input logic [63:0] ta, input logic [63:0] tb,
                          input logic tbin, input int hold, input bit noise);
        logic [63:0] e_diff;
        logic [64:0] e_sub;
        logic        e_bout;
        logic        e_ovf;
        int          lat;
        e_diff = ta - tb - 64'(tbin);
        e_sub  = {1'b0, tb} + 65'(tbin);
        e_bout = ({1'b0, ta} < e_sub);
        e_ovf  = (ta[63] != tb[63]) && (e_diff[63] != ta[63]);

        @(negedge clk);
        chk({name, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        a        = ta;
        b        = tb;
        bin      = tbin;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({name, ".in_ready_run"}, 64'(in_ready), 64'd0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 4 * NS) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                a        = rnd64();
                b        = rnd64();
                bin      = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk({name, ".latency"}, 64'(lat), 64'(NS));
        chk({name, ".diff"}, diff, e_diff);
        chk({name, ".bout"}, 64'(bout), 64'(e_bout));
        chk({name, ".ovf"}, 64'(ovf), 64'(e_ovf));
        chk({name, ".zero"}, 64'(zero), 64'(e_diff == 64'd0));

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, ".hold_valid"}, 64'(out_valid), 64'd1);
            chk({name, ".hold_ready"}, 64'(in_ready), 64'd0);
            chk({name, ".hold_diff"}, diff, e_diff);
            chk({name, ".hold_flags"}, 64'({bout, ovf, zero}),
                64'({e_bout, e_ovf, e_diff == 64'd0}));
        end

        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, ".valid_drop"}, 64'(out_valid), 64'd0);
        chk({name, ".ready_back"}, 64'(in_ready), 64'd1);
        chk({name, ".diff_kept"}, diff, e_diff);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.diff", diff, 64'd0);
        chk("reset.flags", 64'({bout, ovf, zero}), 64'd0);
        rst = 1'b0;

        run_op("T1", 64'd100, 64'd55, 1'b0, 0, 1'b0);
        run_op("T2", 64'd0, 64'd1, 1'b0, 0, 1'b0);
        run_op("T3", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 0, 1'b0);
        run_op("T4a", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 1'b0);
        run_op("T4b", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1, 0, 1'b0);
        run_op("T5", 64'h0100_0000_0000_0000, 64'd1, 1'b0, 0, 1'b0);
        run_op("T6hold", 64'h7FFF_0000_1234_5678, 64'h8000_FFFF_0000_0001, 1'b1, 5, 1'b1);

        for (int i = 0; i < 24; i++) begin
            ra = rnd64();
            rb = (i % 6 == 0) ? ra : rnd64();
            run_op("rand", ra, rb, 1'($urandom_range(0, 1)), i % 3, 1'(i % 2));
        end

        // Reset during the fourth RUN cycle discards the operation
        @(negedge clk);
        a        = 64'hDEAD_BEEF_0000_0001;
        b        = 64'h0000_0000_0000_0002;
        bin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.out_valid", 64'(out_valid), 64'd0);
        chk("midrst.in_ready", 64'(in_ready), 64'd1);
        chk("midrst.diff", diff, 64'd0);
        chk("midrst.flags", 64'({bout, ovf, zero}), 64'd0);
        repeat (NS + 2) @(negedge clk);
        chk("midrst.no_result", 64'(out_valid), 64'd0);

        run_op("after_rst", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_00FF, 1'b1, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
